// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// Provides MDU FSM state encoding, reg-0 constant and operand-match helper.
package hazard_pkg;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int unsigned MDU_CNT_W = 6;

  // r feeds one of the ID operands; r0 is hardwired and never hazards
  function automatic logic reg_match(
    input logic [4:0] r,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return (r != REG_ZERO) &&
           ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/mdu_busy_tracker.sv
// Tracks MULT/DIV occupancy: IDLE -> BUSY on issue, back after LATENCY-1 cycles.
// Ports: clk, rst (sync, active-high), issue (in); busy (out, = state==BUSY).
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int unsigned LATENCY = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic busy
);

  localparam logic [MDU_CNT_W-1:0] CNT_INIT =
    MDU_CNT_W'(LATENCY - 1);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE =
    MDU_CNT_W'(1);

  mdu_state_e           state;
  logic [MDU_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        MDU_IDLE: begin
          if (issue) begin
            state <= MDU_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        MDU_BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE)
            state <= MDU_IDLE;
        end
        default: begin
          state <= MDU_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == MDU_BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID-stage hazard control: load-use, branch-operand, MDU stalls and redirect flush.
// In: clk, rst, ID/EX/MEM operand info; out: pc_wr_en, if_id_wr_en, if_id_flush,
// id_ex_bubble, mdu_busy; stall_cnt/flush_cnt only with HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_mdu_op,
  input  logic             id_reads_hilo,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  output logic             pc_wr_en,
  output logic             if_id_wr_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mdu_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic br_haz;
  logic mdu_haz;
  logic stall;
  logic busy_q;
  logic sel_rst;
  logic sel_stall;
  logic sel_redir;
  logic sel_run;

  assign ex_hit  = reg_match(ex_rd, id_rs,
                             id_rt, id_uses_rt);
  assign mem_hit = reg_match(mem_rd, id_rs,
                             id_rt, id_uses_rt);

  assign load_use = ex_mem_read && ex_hit;
  assign br_haz   = id_is_branch &&
                    ((ex_reg_write && ex_hit) ||
                     (mem_mem_read && mem_hit));
  assign mdu_haz  = mdu_busy &&
                    (id_reads_hilo || id_mdu_op);
  assign stall    = load_use || br_haz || mdu_haz;

  mdu_busy_tracker #(
    .LATENCY (MDU_LATENCY)
  ) u_mdu (
    .clk   (clk),
    .rst   (rst),
    .issue (id_mdu_op && !stall),
    .busy  (busy_q)
  );

  // state may still read BUSY during the reset cycle
  assign mdu_busy = busy_q && !rst;

  // one-hot selects so the decoder below is truly unique
  assign sel_rst   = rst;
  assign sel_stall = !rst && stall;
  assign sel_redir = !rst && !stall &&
                     (branch_taken || jump);
  assign sel_run   = !rst && !stall &&
                     !(branch_taken || jump);

  always_comb begin
    pc_wr_en     = 1'b1;
    if_id_wr_en  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    unique case (1'b1)
      sel_rst, sel_stall: begin
        pc_wr_en     = 1'b0;
        if_id_wr_en  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      sel_redir: begin
        if_id_flush  = 1'b1;
      end
      sel_run: begin
        if_id_flush  = 1'b0;
      end
      default: begin
        id_ex_bubble = 1'b0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: vector table, directed corner
// sequences, and randomized traffic against a timestamp-based reference model.
module tb_hazard_ctrl_unit;

  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       id_uses_rt, id_is_branch, id_mdu_op;
  logic       id_reads_hilo, branch_taken, jump;
  logic       ex_mem_read, ex_reg_write, mem_mem_read;
  logic       pc_wr_en, if_id_wr_en, if_id_flush;
  logic       id_ex_bubble, mdu_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl_unit #(
    .MDU_LATENCY (LAT),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_is_branch  (id_is_branch),
    .id_mdu_op     (id_mdu_op),
    .id_reads_hilo (id_reads_hilo),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .ex_mem_read   (ex_mem_read),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .mem_mem_read  (mem_mem_read),
    .mem_rd        (mem_rd),
    .pc_wr_en      (pc_wr_en),
    .if_id_wr_en   (if_id_wr_en),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .mdu_busy      (mdu_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  // expected output order: {pc, if_id_wr, flush, bubble, busy}
  localparam logic [4:0] E_RUN   = 5'b11000;
  localparam logic [4:0] E_STALL = 5'b00010;
  localparam logic [4:0] E_REDIR = 5'b11100;
  localparam logic [4:0] E_MSTL  = 5'b00011;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       uses_rt, is_br, mdu_op, hilo;
    logic       taken, jmp;
    logic       ex_mr, ex_rw;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic [4:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t nop();
    vec_t v;
    v.rst = 1'b0; v.rs = 5'd0; v.rt = 5'd0;
    v.uses_rt = 1'b0; v.is_br = 1'b0;
    v.mdu_op = 1'b0; v.hilo = 1'b0;
    v.taken = 1'b0; v.jmp = 1'b0;
    v.ex_mr = 1'b0; v.ex_rw = 1'b0; v.ex_rd = 5'd0;
    v.mem_mr = 1'b0; v.mem_rd = 5'd0;
    v.exp = E_RUN;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; id_rs = v.rs; id_rt = v.rt;
    id_uses_rt = v.uses_rt; id_is_branch = v.is_br;
    id_mdu_op = v.mdu_op; id_reads_hilo = v.hilo;
    branch_taken = v.taken; jump = v.jmp;
    ex_mem_read = v.ex_mr; ex_reg_write = v.ex_rw;
    ex_rd = v.ex_rd; mem_mem_read = v.mem_mr;
    mem_rd = v.mem_rd;
  endtask

  task automatic check5(input string nm,
                        input logic [4:0] exp);
    logic [4:0] got;
    got = {pc_wr_en, if_id_wr_en, if_id_flush,
           id_ex_bubble, mdu_busy};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%b exp=%b (pc,ifid,flush,bub,busy)",
               nm, got, exp);
    end
  endtask

  task automatic check_cnt(input string nm,
                           input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // drive away from the rising edge, sample mid-low phase
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    #2;
    check5(nm, v.exp);
  endtask

  vec_t  tbl[13];
  string tnm[13];

  // reference model state: MDU tracked by issue timestamp
  int  cyc;
  int  issue_cyc;
  bit  issue_vld;
  int  m_stall, m_flush;

  function automatic bit hit(input logic [4:0] r,
                             input vec_t v);
    if (r == 5'd0) return 1'b0;
    return (r == v.rs) || (v.uses_rt && r == v.rt);
  endfunction

  initial begin
    vec_t v;
    drive(nop());
    rst = 1'b1;

    // reset state
    @(negedge clk); #2;
    check5("reset_state", E_STALL);
    v = nop(); v.rst = 1'b1; v.exp = E_STALL;
    v.taken = 1'b1; v.mdu_op = 1'b1;
    apply(v, "reset_ignores_inputs");

    for (int i = 0; i < 13; i++) tbl[i] = nop();
    tnm[0] = "idle";
    tbl[1].ex_mr = 1; tbl[1].ex_rw = 1;
    tbl[1].ex_rd = 8; tbl[1].rs = 8;
    tbl[1].exp = E_STALL; tnm[1] = "lu_rs";
    tbl[2].ex_mr = 1; tbl[2].ex_rd = 5;
    tbl[2].rt = 5; tbl[2].uses_rt = 1;
    tbl[2].exp = E_STALL; tnm[2] = "lu_rt";
    tbl[3].ex_mr = 1; tbl[3].ex_rd = 5;
    tbl[3].rt = 5; tnm[3] = "lu_rt_unused";
    tbl[4].ex_mr = 1; tnm[4] = "lu_r0";
    tbl[5].is_br = 1; tbl[5].ex_rw = 1;
    tbl[5].ex_rd = 9; tbl[5].rs = 9;
    tbl[5].exp = E_STALL; tnm[5] = "br_ex";
    tbl[6].is_br = 1; tbl[6].mem_mr = 1;
    tbl[6].mem_rd = 9; tbl[6].rt = 9;
    tbl[6].uses_rt = 1;
    tbl[6].exp = E_STALL; tnm[6] = "br_mem";
    tbl[7].ex_rw = 1; tbl[7].ex_rd = 9;
    tbl[7].rs = 9; tnm[7] = "alu_fwd_no_br";
    tbl[8].jmp = 1; tbl[8].exp = E_REDIR;
    tnm[8] = "jump";
    tbl[9].taken = 1; tbl[9].exp = E_REDIR;
    tnm[9] = "taken";
    tbl[10].ex_mr = 1; tbl[10].ex_rd = 3;
    tbl[10].rs = 3; tbl[10].taken = 1;
    tbl[10].exp = E_STALL; tnm[10] = "stall_beats_taken";
    tbl[11].is_br = 1; tbl[11].mem_rd = 9;
    tbl[11].rs = 9; tnm[11] = "br_mem_nonload";
    tbl[12].hilo = 1; tnm[12] = "hilo_idle";

    for (int i = 0; i < 13; i++) apply(tbl[i], tnm[i]);

    // T1 load-use stalls once, then runs with bubble in EX
    v = nop(); v.ex_mr = 1; v.ex_rd = 8; v.rs = 8;
    v.exp = E_STALL; apply(v, "t1_stall");
    v.ex_mr = 0; v.ex_rd = 0; v.exp = E_RUN;
    apply(v, "t1_run");

    // T2 register 0 never hazards
    v = nop(); v.ex_mr = 1; v.ex_rd = 0; v.rs = 0;
    apply(v, "t2_r0");

    // T3 branch waits on EX, then MEM load, then redirects
    v = nop(); v.is_br = 1; v.rs = 9;
    v.ex_rw = 1; v.ex_rd = 9; v.exp = E_STALL;
    apply(v, "t3_br_ex");
    v.ex_rw = 0; v.ex_rd = 0;
    v.mem_mr = 1; v.mem_rd = 9;
    apply(v, "t3_br_mem");
    v.mem_mr = 0; v.mem_rd = 0; v.taken = 1;
    v.exp = E_REDIR; apply(v, "t3_flush");
    v = nop(); apply(v, "t3_after");

    // T5 mult then MFLO: 3 stall cycles, runs on the 4th
    v = nop(); v.mdu_op = 1; apply(v, "t5_issue");
    v = nop(); v.hilo = 1; v.exp = E_MSTL;
    for (int i = 0; i < LAT - 1; i++)
      apply(v, $sformatf("t5_busy%0d", i));
    v.exp = E_RUN; apply(v, "t5_mflo_runs");

    // T6 reset mid-BUSY
    v = nop(); v.mdu_op = 1; apply(v, "t6_issue");
    v = nop(); v.hilo = 1; v.exp = E_MSTL;
    apply(v, "t6_busy");
    v.rst = 1; v.exp = E_STALL;
    apply(v, "t6_rst");
    v.rst = 0; v.exp = E_RUN;
    apply(v, "t6_mflo_after_rst");
`ifdef HAZARD_PERF_CNT_EN
    check_cnt("t6_stall_cnt", int'(stall_cnt), 0);
    check_cnt("t6_flush_cnt", int'(flush_cnt), 0);
`endif

    // randomized traffic against reference model
    v = nop(); v.rst = 1; v.exp = E_STALL;
    apply(v, "rand_reset");
    cyc = 0; issue_vld = 0; issue_cyc = 0;
    m_stall = 0; m_flush = 0;
    for (int n = 0; n < 600; n++) begin
      bit busy, lu, bh, mh, st, rd;
      int age;
      v = nop();
      v.rst     = ($urandom_range(0, 60) == 0);
      v.rs      = 5'($urandom_range(0, 3));
      v.rt      = 5'($urandom_range(0, 3));
      v.ex_rd   = 5'($urandom_range(0, 3));
      v.mem_rd  = 5'($urandom_range(0, 3));
      v.uses_rt = ($urandom_range(0, 1) == 0);
      v.is_br   = ($urandom_range(0, 2) == 0);
      v.mdu_op  = ($urandom_range(0, 3) == 0);
      v.hilo    = ($urandom_range(0, 2) == 0);
      v.taken   = ($urandom_range(0, 3) == 0);
      v.jmp     = ($urandom_range(0, 7) == 0);
      v.ex_mr   = ($urandom_range(0, 3) == 0);
      v.ex_rw   = ($urandom_range(0, 1) == 0);
      v.mem_mr  = ($urandom_range(0, 3) == 0);

      age  = cyc - issue_cyc;
      busy = !v.rst && issue_vld &&
             age >= 1 && age <= LAT - 1;
      lu = v.ex_mr && hit(v.ex_rd, v);
      bh = v.is_br &&
           ((v.ex_rw && hit(v.ex_rd, v)) ||
            (v.mem_mr && hit(v.mem_rd, v)));
      mh = busy && (v.hilo || v.mdu_op);
      st = lu || bh || mh;
      rd = !st && (v.taken || v.jmp);
      if (v.rst)   v.exp = E_STALL;
      else if (st) v.exp = {4'b0001, busy};
      else if (rd) v.exp = {4'b1110, busy};
      else         v.exp = {4'b1100, busy};

      apply(v, $sformatf("rand%0d", n));
`ifdef HAZARD_PERF_CNT_EN
      check_cnt($sformatf("rand%0d_stall_cnt", n),
                int'(stall_cnt), m_stall);
      check_cnt($sformatf("rand%0d_flush_cnt", n),
                int'(flush_cnt), m_flush);
`endif

      if (v.rst) begin
        issue_vld = 0;
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (v.mdu_op && !st) begin
          issue_vld = 1;
          issue_cyc = cyc;
        end
        if (st && m_stall < SAT) m_stall++;
        if (rd && m_flush < SAT) m_flush++;
      end
      cyc++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
